// File: rtl/switch_event_ctrl_pkg.sv
// Shared definitions for the switch event front-end.
//   - hold_state_e     : per-channel hold FSM encoding
//   - c_DEF_*          : default timing constants for a 25 MHz clock
//   - max_int()        : helper used to size shared counters
package switch_event_pkg;

  typedef enum logic [1:0] {
    HOLD_IDLE = 2'd0,
    HOLD_HELD = 2'd1,
    HOLD_LONG = 2'd2
  } hold_state_e;

  localparam int c_DEF_DEBOUNCE_CYCLES   = 250000;    // 10 ms
  localparam int c_DEF_LONG_PRESS_CYCLES = 12500000;  // 500 ms
  localparam int c_DEF_REPEAT_CYCLES     = 2500000;   // 100 ms

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/switch_event_ctrl_channel.sv
// One push-button channel: 2-flop synchroniser, debounce counter and
// hold FSM (IDLE/HELD/LONG). All event outputs are registered 1-cycle pulses.
// Ports:
//   i_Clk, i_Rst_L       clock, async active-low reset
//   i_Switch             raw asynchronous switch input
//   o_Level              debounced level
//   o_Press / o_Release  debounced rise / fall pulses
//   o_Long               long-press threshold pulse
//   o_Repeat             auto-repeat pulses (only when c_REPEAT_EN)
//   o_Short_Release      release pulse that ended a HELD (not LONG) press
module switch_channel
  import switch_event_pkg::*;
#(
  parameter int c_DEBOUNCE_CYCLES   = c_DEF_DEBOUNCE_CYCLES,
  parameter int c_LONG_PRESS_CYCLES = c_DEF_LONG_PRESS_CYCLES,
  parameter int c_REPEAT_CYCLES     = c_DEF_REPEAT_CYCLES,
  parameter bit c_REPEAT_EN         = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Level,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long,
  output logic o_Repeat,
  output logic o_Short_Release
);

  localparam int c_DB_W   = $clog2(c_DEBOUNCE_CYCLES + 1);
  localparam int c_HOLD_W = $clog2(max_int(c_LONG_PRESS_CYCLES, c_REPEAT_CYCLES) + 1);
  // Thresholds are compared against the count before the edge, hence the -1.
  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(c_DEBOUNCE_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_LONG_LAST = c_HOLD_W'(c_LONG_PRESS_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_REP_LAST  = c_HOLD_W'(c_REPEAT_CYCLES - 1);

  logic                r_Sync1, r_Sync2;
  logic [c_DB_W-1:0]   r_Db_Cnt, w_Db_Next;
  logic                r_Level;
  logic                w_Toggle, w_Rise, w_Fall;
  hold_state_e         r_State, w_State_Next;
  logic [c_HOLD_W-1:0] r_Hold_Cnt, w_Hold_Next;
  logic                r_Press, r_Release, r_Long, r_Repeat, r_Short_Rel;
  logic                w_Long, w_Repeat, w_Short_Rel;

  // Debounce: count consecutive cycles the synchronised input differs from the stable level.
  always_comb begin
    w_Db_Next = r_Db_Cnt;
    w_Toggle  = 1'b0;
    if (r_Sync2 == r_Level) begin
      w_Db_Next = '0;
    end else if (r_Db_Cnt >= c_DB_LAST) begin
      w_Toggle  = 1'b1;
      w_Db_Next = '0;
    end else begin
      w_Db_Next = r_Db_Cnt + c_DB_W'(1);
    end
  end

  assign w_Rise = w_Toggle & r_Sync2;
  assign w_Fall = w_Toggle & ~r_Sync2;

  // Hold FSM next state; a debounced fall overrides whatever the state would do.
  always_comb begin
    w_State_Next = r_State;
    w_Hold_Next  = r_Hold_Cnt;
    w_Long       = 1'b0;
    w_Repeat     = 1'b0;
    w_Short_Rel  = 1'b0;
    if (w_Fall) begin
      w_State_Next = HOLD_IDLE;
      w_Hold_Next  = '0;
      w_Short_Rel  = (r_State == HOLD_HELD);
    end else begin
      case (r_State)
        HOLD_IDLE: begin
          w_Hold_Next = '0;
          if (w_Rise) begin
            w_State_Next = HOLD_HELD;
          end else begin
            w_State_Next = HOLD_IDLE;
          end
        end
        HOLD_HELD: begin
          if (r_Hold_Cnt >= c_LONG_LAST) begin
            w_Long       = 1'b1;
            w_State_Next = HOLD_LONG;
            w_Hold_Next  = '0;
          end else begin
            w_Hold_Next = r_Hold_Cnt + c_HOLD_W'(1);
          end
        end
        HOLD_LONG: begin
          if (!c_REPEAT_EN) begin
            w_Hold_Next = '0;
          end else if (r_Hold_Cnt >= c_REP_LAST) begin
            w_Repeat    = 1'b1;
            w_Hold_Next = '0;
          end else begin
            w_Hold_Next = r_Hold_Cnt + c_HOLD_W'(1);
          end
        end
        default: begin
          w_State_Next = HOLD_IDLE;
          w_Hold_Next  = '0;
        end
      endcase
    end
  end

  // State, counters and registered event pulses.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Sync1     <= 1'b0;
      r_Sync2     <= 1'b0;
      r_Db_Cnt    <= '0;
      r_Level     <= 1'b0;
      r_State     <= HOLD_IDLE;
      r_Hold_Cnt  <= '0;
      r_Press     <= 1'b0;
      r_Release   <= 1'b0;
      r_Long      <= 1'b0;
      r_Repeat    <= 1'b0;
      r_Short_Rel <= 1'b0;
    end else begin
      r_Sync1     <= i_Switch;
      r_Sync2     <= r_Sync1;
      r_Db_Cnt    <= w_Db_Next;
      r_Level     <= r_Level ^ w_Toggle;
      r_State     <= w_State_Next;
      r_Hold_Cnt  <= w_Hold_Next;
      r_Press     <= w_Rise;
      r_Release   <= w_Fall;
      r_Long      <= w_Long;
      r_Repeat    <= w_Repeat;
      r_Short_Rel <= w_Short_Rel;
    end
  end

  assign o_Level         = r_Level;
  assign o_Press         = r_Press;
  assign o_Release       = r_Release;
  assign o_Long          = r_Long;
  assign o_Repeat        = r_Repeat;
  assign o_Short_Release = r_Short_Rel;

endmodule

// File: rtl/switch_event_ctrl.sv
// Push-button front-end: N independent debounced channels with press,
// release, long-press and auto-repeat pulses, plus a wrapping mode selector
// advanced by channel c_SEL_CH.
// Ports:
//   i_Clk, i_Rst_L   clock, async active-low reset
//   i_Switch[N]      raw switches (asynchronous)
//   i_Sel_Clear      synchronous selector clear (wins over an advance)
//   o_Level/o_Press/o_Release/o_Long/o_Repeat [N]  per-channel outputs
//   o_Select         selector value, o_Select_Wrap pulses on wrap to 0
module switch_event_ctrl
  import switch_event_pkg::*;
#(
  parameter int                        c_NUM_SWITCHES      = 4,
  parameter int                        c_DEBOUNCE_CYCLES   = c_DEF_DEBOUNCE_CYCLES,
  parameter int                        c_LONG_PRESS_CYCLES = c_DEF_LONG_PRESS_CYCLES,
  parameter int                        c_REPEAT_CYCLES     = c_DEF_REPEAT_CYCLES,
  parameter logic [c_NUM_SWITCHES-1:0] c_REPEAT_MASK       = c_NUM_SWITCHES'(4'b0110),
  parameter int                        c_SEL_CH            = 0,
  parameter int                        c_SEL_MAX           = 7,
  parameter int                        c_SEL_WIDTH         = 4,
  parameter int                        c_SEL_ON_RELEASE    = 1
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_L,
  input  logic [c_NUM_SWITCHES-1:0] i_Switch,
  input  logic                      i_Sel_Clear,
  output logic [c_NUM_SWITCHES-1:0] o_Level,
  output logic [c_NUM_SWITCHES-1:0] o_Press,
  output logic [c_NUM_SWITCHES-1:0] o_Release,
  output logic [c_NUM_SWITCHES-1:0] o_Long,
  output logic [c_NUM_SWITCHES-1:0] o_Repeat,
  output logic [c_SEL_WIDTH-1:0]    o_Select,
  output logic                      o_Select_Wrap
);

  localparam logic [c_NUM_SWITCHES-1:0] c_SEL_ONEHOT = c_NUM_SWITCHES'(1) << c_SEL_CH;
  localparam logic [c_SEL_WIDTH-1:0]    c_SEL_LAST   = c_SEL_WIDTH'(c_SEL_MAX);

  logic [c_NUM_SWITCHES-1:0] w_Short_Rel;
  logic                      w_Adv;
  logic [c_SEL_WIDTH-1:0]    r_Select, w_Select_Next;
  logic                      r_Wrap, w_Wrap_Next;

  for (genvar g = 0; g < c_NUM_SWITCHES; g++) begin : g_ch
    switch_channel #(
      .c_DEBOUNCE_CYCLES   (c_DEBOUNCE_CYCLES),
      .c_LONG_PRESS_CYCLES (c_LONG_PRESS_CYCLES),
      .c_REPEAT_CYCLES     (c_REPEAT_CYCLES),
      .c_REPEAT_EN         (c_REPEAT_MASK[g])
    ) u_ch (
      .i_Clk           (i_Clk),
      .i_Rst_L         (i_Rst_L),
      .i_Switch        (i_Switch[g]),
      .o_Level         (o_Level[g]),
      .o_Press         (o_Press[g]),
      .o_Release       (o_Release[g]),
      .o_Long          (o_Long[g]),
      .o_Repeat        (o_Repeat[g]),
      .o_Short_Release (w_Short_Rel[g])
    );
  end

  // The trigger is the registered pulse, so the selector moves one cycle after the event.
  assign w_Adv = (c_SEL_ON_RELEASE != 0) ? |(w_Short_Rel & c_SEL_ONEHOT)
                                         : |(o_Press & c_SEL_ONEHOT);

  // Selector next value: clear beats advance and suppresses the wrap pulse.
  always_comb begin
    w_Select_Next = r_Select;
    w_Wrap_Next   = 1'b0;
    if (i_Sel_Clear) begin
      w_Select_Next = '0;
    end else if (w_Adv) begin
      if (r_Select >= c_SEL_LAST) begin
        w_Select_Next = '0;
        w_Wrap_Next   = 1'b1;
      end else begin
        w_Select_Next = r_Select + c_SEL_WIDTH'(1);
      end
    end else begin
      w_Select_Next = r_Select;
    end
  end

  // Selector registers.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Select <= '0;
      r_Wrap   <= 1'b0;
    end else begin
      r_Select <= w_Select_Next;
      r_Wrap   <= w_Wrap_Next;
    end
  end

  assign o_Select      = r_Select;
  assign o_Select_Wrap = r_Wrap;

endmodule

// File: tb/tb_switch_event_ctrl.sv
// Directed bench for switch_event_ctrl with short timing parameters.
module tb_switch_event_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       sel_clear;
  logic [3:0] o_Level, o_Press, o_Release, o_Long, o_Repeat;
  logic [3:0] o_Select;
  logic       o_Select_Wrap;

  int checks   = 0;
  int failures = 0;
  int n_rep0   = 0;
  int n_rep23  = 0;
  int n_wrap   = 0;

  switch_event_ctrl #(
    .c_NUM_SWITCHES      (4),
    .c_DEBOUNCE_CYCLES   (4),
    .c_LONG_PRESS_CYCLES (20),
    .c_REPEAT_CYCLES     (5),
    .c_REPEAT_MASK       (4'b0110),
    .c_SEL_CH            (0),
    .c_SEL_MAX           (2),
    .c_SEL_WIDTH         (4),
    .c_SEL_ON_RELEASE    (1)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Switch      (sw),
    .i_Sel_Clear   (sel_clear),
    .o_Level       (o_Level),
    .o_Press       (o_Press),
    .o_Release     (o_Release),
    .o_Long        (o_Long),
    .o_Repeat      (o_Repeat),
    .o_Select      (o_Select),
    .o_Select_Wrap (o_Select_Wrap)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (o_Repeat[0]) n_rep0 = n_rep0 + 1;
    if (o_Repeat[3] | o_Repeat[2]) n_rep23 = n_rep23 + 1;
    if (o_Select_Wrap) n_wrap = n_wrap + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Short press on ch0 (10 cycles held), checks release and resulting selector.
  task automatic short_press(input logic [3:0] exp_sel, input logic exp_wrap);
    sw[0] = 1'b1;
    tick(6);
    check_eq("sp_press", 32'(o_Press[0]), 32'd1);
    tick(4);
    sw[0] = 1'b0;
    tick(6);
    check_eq("sp_release", 32'(o_Release[0]), 32'd1);
    tick(1);
    check_eq("sp_select", 32'(o_Select), 32'(exp_sel));
    check_eq("sp_wrap", 32'(o_Select_Wrap), 32'(exp_wrap));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_long;
    logic [1:0] exp_rep;
    rst_n     = 1'b0;
    sw        = 4'b0000;
    sel_clear = 1'b0;
    tick(3);
    check_eq("rst_level", 32'(o_Level), 32'd0);
    check_eq("rst_select", 32'(o_Select), 32'd0);
    check_eq("rst_pulses", 32'({o_Press, o_Release, o_Long, o_Repeat, o_Select_Wrap}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Glitch of 3 cycles on ch0 must be ignored.
    sw[0] = 1'b1;
    tick(3);
    sw[0] = 1'b0;
    tick(10);
    check_eq("glitch_level", 32'(o_Level), 32'd0);

    // Exact latency of the first press/release on ch0.
    sw[0] = 1'b1;
    tick(5);
    check_eq("lat_level_e5", 32'(o_Level[0]), 32'd0);
    tick(1);
    check_eq("lat_level_e6", 32'(o_Level[0]), 32'd1);
    check_eq("lat_press_e6", 32'(o_Press), 32'b0001);
    tick(1);
    check_eq("lat_press_1cyc", 32'(o_Press), 32'd0);
    sw[0] = 1'b0;
    tick(5);
    check_eq("lat_rel_e5", 32'(o_Release[0]), 32'd0);
    tick(1);
    check_eq("lat_rel_e6", 32'(o_Release), 32'b0001);
    check_eq("lat_rel_level", 32'(o_Level[0]), 32'd0);
    check_eq("lat_sel_before", 32'(o_Select), 32'd0);
    tick(1);
    check_eq("lat_sel_after", 32'(o_Select), 32'd1);

    // Ch0 and ch1 held together: long on both, repeat only on ch1.
    sw[1:0] = 2'b11;
    tick(6);
    check_eq("hold_press", 32'(o_Press), 32'b0011);
    for (int k = 1; k <= 39; k++) begin
      tick(1);
      exp_long = (k == 20) ? 2'b11 : 2'b00;
      exp_rep  = (k == 25 || k == 30 || k == 35) ? 2'b10 : 2'b00;
      check_eq($sformatf("hold_long_rep_k%0d", k),
               32'({o_Long[1:0], o_Repeat[1:0]}), 32'({exp_long, exp_rep}));
    end
    sw[1:0] = 2'b00;
    tick(6);
    check_eq("hold_release", 32'(o_Release), 32'b0011);
    tick(2);
    check_eq("long_no_advance", 32'(o_Select), 32'd1);
    check_eq("no_rep_ch0", 32'(n_rep0), 32'd0);
    check_eq("no_rep_ch23", 32'(n_rep23), 32'd0);

    // Selector advance and wrap.
    short_press(4'd2, 1'b0);
    short_press(4'd0, 1'b1);
    tick(1);
    check_eq("wrap_1cyc", 32'(o_Select_Wrap), 32'd0);
    short_press(4'd1, 1'b0);
    short_press(4'd2, 1'b0);

    // Clear coincident with an advance at the last value: 0 and no wrap.
    sw[0] = 1'b1;
    tick(10);
    sw[0] = 1'b0;
    tick(6);
    check_eq("clr_release", 32'(o_Release[0]), 32'd1);
    sel_clear = 1'b1;
    tick(1);
    sel_clear = 1'b0;
    check_eq("clr_select", 32'(o_Select), 32'd0);
    check_eq("clr_no_wrap", 32'(o_Select_Wrap), 32'd0);
    check_eq("wrap_count", 32'(n_wrap), 32'd1);

    short_press(4'd1, 1'b0);

    // Async reset mid-HELD, then re-press with the switch still high.
    sw[0] = 1'b1;
    tick(8);
    check_eq("mid_held_level", 32'(o_Level[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_level", 32'(o_Level), 32'd0);
    check_eq("async_rst_select", 32'(o_Select), 32'd0);
    check_eq("async_rst_pulses", 32'({o_Press, o_Release, o_Long, o_Repeat, o_Select_Wrap}), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check_eq("post_rst_e5", 32'(o_Press[0]), 32'd0);
    tick(1);
    check_eq("post_rst_press", 32'(o_Press), 32'b0001);
    check_eq("post_rst_level", 32'(o_Level[0]), 32'd1);
    sw[0] = 1'b0;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/switch_event_ctrl.md
# switch_event_ctrl

Parametrised front-end for the board push-buttons. It replaces the fixed four-instance debounce plus hand-written release-edge counter in the game top with one block. For N switches it provides synchronised, debounced levels and single-cycle press/release/long-press/auto-repeat events, plus a wrapping mode-select counter driven by one chosen channel. It sits between the `i_Switch_*` pins and the pong core, test-pattern selector and LEDs.

## Interface
Parameters:
- `c_NUM_SWITCHES`, 4: channel count N, ≥1.
- `c_DEBOUNCE_CYCLES`, 250000: consecutive stable cycles needed to accept a level change (10 ms at 25 MHz), ≥1.
- `c_LONG_PRESS_CYCLES`, 12500000: held cycles after press before the long-press event, ≥1.
- `c_REPEAT_CYCLES`, 2500000: auto-repeat period after long press, ≥1.
- `c_REPEAT_MASK`, N'b0110: per-channel auto-repeat enable.
- `c_SEL_CH`, 0: channel that drives the selector.
- `c_SEL_MAX`, 7: last selector value before wrap.
- `c_SEL_WIDTH`, 4: selector width; must hold `c_SEL_MAX`.
- `c_SEL_ON_RELEASE`, 1: 1 = advance on short-press release; 0 = advance on press.

Ports:
- `i_Clk` in 1: system clock (25 MHz pixel clock).
- `i_Rst_L` in 1: reset, asynchronous, active-low.
- `i_Switch` in N: raw active-high switches, asynchronous to `i_Clk`.
- `i_Sel_Clear` in 1: synchronous clear of the selector to 0.
- `o_Level` out N: debounced level.
- `o_Press` out N: 1-cycle pulse when the debounced level rises.
- `o_Release` out N: 1-cycle pulse when the debounced level falls.
- `o_Long` out N: 1-cycle pulse, long-press threshold reached.
- `o_Repeat` out N: 1-cycle auto-repeat pulses, masked channels only.
- `o_Select` out `c_SEL_WIDTH`: mode selector value.
- `o_Select_Wrap` out 1: 1-cycle pulse when `o_Select` wraps from `c_SEL_MAX` to 0.

## Operation
- Per channel: 2-flop synchroniser, then a debounce counter. The counter resets whenever the synchronised input equals the stable level. It increments otherwise. When it reaches `c_DEBOUNCE_CYCLES`, the stable level toggles and the counter clears.
- Per-channel hold FSM has three states: IDLE, HELD, LONG.
  - IDLE → HELD on debounced rise. Assert `o_Press` and clear the hold counter.
  - HELD: count up. At `c_LONG_PRESS_CYCLES`, pulse `o_Long` and go to LONG. Clear the counter.
  - LONG: for masked channels, pulse `o_Repeat` every `c_REPEAT_CYCLES`.
  - Any state → IDLE on debounced fall, with `o_Release`.
- Selector:
  - With `c_SEL_ON_RELEASE`=1, it advances only on a release from HELD. A release from LONG does not advance it.
  - With `c_SEL_ON_RELEASE`=0, it advances on `o_Press` of `c_SEL_CH`.
  - On advance at `c_SEL_MAX`, it loads 0 and pulses `o_Select_Wrap`.
  - `i_Sel_Clear` has priority over an advance in the same cycle; no wrap pulse is generated.
- Counters are sized to `$clog2(max+1)` and saturate. None wrap.

## Timing
- Reset (`i_Rst_L`=0): all flops, counters, FSMs and outputs go to 0 immediately. Selector = 0.
- After reset release with a switch already high, a full debounce runs, then `o_Press` fires. There is no suppression.
- Latency: `o_Level` changes exactly `c_DEBOUNCE_CYCLES`+2 rising edges after `i_Switch` changes and then stays stable. `o_Press`/`o_Release` are asserted in the same cycle `o_Level` changes.
- Glitches shorter than `c_DEBOUNCE_CYCLES` cycles produce no event.
- `o_Long` fires `c_LONG_PRESS_CYCLES` cycles after `o_Press`. `o_Repeat` fires `c_REPEAT_CYCLES`·k cycles after `o_Long`, for k ≥ 1.
- `o_Select` updates one cycle after the triggering event pulse. `o_Select_Wrap` is coincident with the load of 0.
- Channels are independent. Simultaneous events on several channels all appear in the same cycle.

## Structure
- Shared package `switch_event_pkg` holds the hold-FSM state encoding (IDLE=2'd0, HELD=2'd1, LONG=2'd2) and the default timing constants for 25 MHz.
- Sub-module `switch_channel` contains the synchroniser, debounce and hold FSM for one channel. It is generated `c_NUM_SWITCHES` times. The top adds the selector logic.

## Test plan
Bench parameters: DEBOUNCE=4, LONG=20, REPEAT=5, SEL_MAX=2, N=4, mask 4'b0110.
- Ch0 high for 3 cycles then low → no `o_Level` change, no pulses.
- Ch0 rise held stable → `o_Level[0]` and `o_Press[0]` at edge 6. Fall → `o_Release[0]` at edge 6 after the fall.
- Ch1 held 40 cycles past press → `o_Long[1]` at +20. `o_Repeat[1]` at +25, +30, +35.
- Ch0 held the same 40 cycles → `o_Long[0]` only, no `o_Repeat[0]`.
- Three short presses on ch0 → `o_Select` 1, 2, 0, with `o_Select_Wrap` on the third. A long press of ch0 leaves `o_Select` unchanged.
- Drive `i_Rst_L` low mid-HELD → all outputs 0 asynchronously. Release with the switch high → `o_Press` 6 edges later. `i_Sel_Clear` coincident with an advance → `o_Select`=0, no wrap pulse.
